// File: rtl/vga_axil_pkg.sv
// Shared types, register offsets and address decode for the VGA AXI4-Lite register bank.
package vga_axil_pkg;

    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned BG_COLOR_W  = 12;

    typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
    typedef logic [AXIL_DATA_W-1:0] axil_data_t;
    typedef logic [1:0]             axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;

    localparam axil_addr_t CTRL_OFS     = 32'h0000_0000;
    localparam axil_addr_t BG_COLOR_OFS = 32'h0000_0004;
    localparam axil_addr_t STATUS_OFS   = 32'h0000_0008;
    localparam axil_addr_t IRQ_OFS      = 32'h0000_000C;
    localparam axil_addr_t SCRATCH_OFS  = 32'h0000_0010;

    typedef struct packed {
        logic test_pattern;
        logic en;
    } ctrl_t;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    typedef enum logic [2:0] {
        SEL_CTRL, SEL_BG_COLOR, SEL_STATUS, SEL_IRQ, SEL_SCRATCH, SEL_NONE
    } reg_sel_t;

    // Word-address decode; any set bit above the 32-byte window is unmapped.
    function automatic reg_sel_t decode_addr(input logic [AXIL_ADDR_W-1:2] word_addr);
        reg_sel_t sel;
        sel = SEL_NONE;
        if (word_addr[AXIL_ADDR_W-1:5] == '0) begin
            case (word_addr[4:2])
                CTRL_OFS[4:2]:     sel = SEL_CTRL;
                BG_COLOR_OFS[4:2]: sel = SEL_BG_COLOR;
                STATUS_OFS[4:2]:   sel = SEL_STATUS;
                IRQ_OFS[4:2]:      sel = SEL_IRQ;
                SCRATCH_OFS[4:2]:  sel = SEL_SCRATCH;
                default:           sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/vga_axil_strb_merge.sv
// Byte-lane merge of a register's current value with strobed write data.
module vga_axil_strb_merge #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < int'(DATA_W / 8); i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/vga_axil_regs.sv
// AXI4-Lite slave holding the VGA control/status registers, with independent read and write FSMs.
module vga_axil_regs
    import vga_axil_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [DATA_W-1:0]      rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic [ADDR_W-1:0]      awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic                   vsync_i,
    output logic                   en_o,
    output logic                   test_pat_o,
    output logic [BG_COLOR_W-1:0]  bg_color_o,
    output logic                   irq_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    w_state_t                w_state, w_state_n;
    r_state_t                r_state, r_state_n;
    logic                    aw_held, aw_held_n, w_held, w_held_n;
    logic [ADDR_W-1:0]       aw_addr_q;
    logic [DATA_W-1:0]       w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    axil_resp_t              bresp_q, bresp_n, rresp_q, rresp_n;
    logic [DATA_W-1:0]       rdata_q, rdata_n;

    ctrl_t                   ctrl_q;
    logic [BG_COLOR_W-1:0]   bg_q;
    logic [DATA_W-1:0]       scratch_q;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q;
    logic                    frame_done_q, vs_d;

    logic aw_hs, w_hs, ar_hs, commit, irq_clr, vs_rise;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data, wr_old, merged, rd_val;
    logic [STRB_W-1:0]  wr_strb;
    axil_addr_t         wr_addr_ext, ar_addr_ext;
    reg_sel_t           wr_sel, ar_sel;
    logic               unused_addr_lsbs;

    // Readies depend only on FSM state and are forced low in reset.
    assign awready = !rst && (w_state == W_IDLE) && !aw_held;
    assign wready  = !rst && (w_state == W_IDLE) && !w_held;
    assign arready = !rst && (r_state == R_IDLE);
    assign bvalid  = (w_state == W_RESP);
    assign rvalid  = (r_state == R_DATA);
    assign bresp   = bresp_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    assign wr_addr = aw_held ? aw_addr_q : awaddr;
    assign wr_data = w_held  ? w_data_q  : wdata;
    assign wr_strb = w_held  ? w_strb_q  : wstrb;
    assign commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_addr_ext = AXIL_ADDR_W'(wr_addr);
    assign ar_addr_ext = AXIL_ADDR_W'(araddr);
    assign wr_sel      = decode_addr(wr_addr_ext[AXIL_ADDR_W-1:2]);
    assign ar_sel      = decode_addr(ar_addr_ext[AXIL_ADDR_W-1:2]);
    assign unused_addr_lsbs = ^{wr_addr_ext[1:0], ar_addr_ext[1:0]};

    assign irq_clr = commit && (wr_sel == SEL_IRQ) && wr_strb[0] && wr_data[0];
    assign vs_rise = vsync_i && !vs_d;

    always_comb begin
        wr_old = '0;
        case (wr_sel)
            SEL_CTRL:     wr_old = DATA_W'(ctrl_q);
            SEL_BG_COLOR: wr_old = DATA_W'(bg_q);
            SEL_SCRATCH:  wr_old = scratch_q;
            default:      wr_old = '0;
        endcase
    end

    vga_axil_strb_merge #(.DATA_W(DATA_W)) u_merge (
        .old_data (wr_old),
        .wdata    (wr_data),
        .wstrb    (wr_strb),
        .merged   (merged)
    );

    always_comb begin
        rd_val = '0;
        case (ar_sel)
            SEL_CTRL:     rd_val = DATA_W'(ctrl_q);
            SEL_BG_COLOR: rd_val = DATA_W'(bg_q);
            SEL_STATUS:   rd_val = DATA_W'({frame_cnt_q, 15'b0, vsync_i});
            SEL_IRQ:      rd_val = DATA_W'(frame_done_q);
            SEL_SCRATCH:  rd_val = scratch_q;
            default:      rd_val = '0;
        endcase
    end

    // Write and read FSM next-state.
    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        bresp_n   = bresp_q;
        r_state_n = r_state;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs) aw_held_n = 1'b1;
                if (w_hs)  w_held_n  = 1'b1;
                if (commit) begin
                    w_state_n = W_RESP;
                    bresp_n   = (wr_sel == SEL_NONE || wr_sel == SEL_STATUS) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_n = W_IDLE;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                end
            end
        endcase
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_n = R_DATA;
                    rdata_n   = rd_val;
                    rresp_n   = (ar_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (rready) r_state_n = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            r_state      <= R_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bresp_q      <= RESP_OKAY;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            ctrl_q       <= '0;
            bg_q         <= '0;
            scratch_q    <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            vs_d         <= 1'b0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            bresp_q <= bresp_n;
            rresp_q <= rresp_n;
            rdata_q <= rdata_n;
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                case (wr_sel)
                    SEL_CTRL:     ctrl_q    <= ctrl_t'(merged[$bits(ctrl_t)-1:0]);
                    SEL_BG_COLOR: bg_q      <= merged[BG_COLOR_W-1:0];
                    SEL_SCRATCH:  scratch_q <= merged;
                    default:      ;
                endcase
            end
            vs_d <= vsync_i;
            if (vs_rise) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            // A new frame beats a simultaneous W1C.
            if (vs_rise)      frame_done_q <= 1'b1;
            else if (irq_clr) frame_done_q <= 1'b0;
        end
    end

    assign en_o       = ctrl_q.en;
    assign test_pat_o = ctrl_q.test_pattern;
    assign bg_color_o = bg_q;
    assign irq_o      = frame_done_q;

endmodule

// File: tb/tb_vga_axil_regs.sv
// Randomized bench for vga_axil_regs against a transaction-level register-map model.
module tb_vga_axil_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;
    logic        vsync_i, en_o, test_pat_o, irq_o;
    logic [11:0] bg_color_o;

    always #5 clk = ~clk;

    vga_axil_regs dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .vsync_i(vsync_i), .en_o(en_o), .test_pat_o(test_pat_o),
        .bg_color_o(bg_color_o), .irq_o(irq_o)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model state: register contents as the register map defines them.
    logic [31:0] m_ctrl, m_bg, m_scratch;
    logic [15:0] m_cnt;
    logic        m_fd, m_vs;
    logic        m_commit;
    logic [31:0] m_wa, m_wd;
    logic [3:0]  m_ws;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        if (a >= 32'h20) return 7;
        return int'(a[4:2]);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        case (m_idx(a))
            0: return m_ctrl;
            1: return m_bg;
            2: return {m_cnt, 15'b0, vsync_i};
            3: return {31'b0, m_fd};
            4: return m_scratch;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] m_rresp(input logic [31:0] a);
        return (m_idx(a) > 4) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] m_bresp(input logic [31:0] a);
        return (m_idx(a) > 4 || m_idx(a) == 2) ? 2'b10 : 2'b00;
    endfunction

    // Model update at each edge; frame-done set is applied after the W1C so it wins.
    always @(posedge clk) begin
        if (rst) begin
            m_ctrl = 0; m_bg = 0; m_scratch = 0; m_cnt = 0; m_fd = 0; m_vs = 0;
        end else begin
            if (m_commit) begin
                case (m_idx(m_wa))
                    0: m_ctrl    = m_merge(m_ctrl, m_wd, m_ws) & 32'h3;
                    1: m_bg      = m_merge(m_bg, m_wd, m_ws) & 32'hFFF;
                    3: if (m_ws[0] && m_wd[0]) m_fd = 1'b0;
                    4: m_scratch = m_merge(m_scratch, m_wd, m_ws);
                    default: ;
                endcase
            end
            if (vsync_i && !m_vs) begin
                m_cnt = m_cnt + 16'd1;
                m_fd  = 1'b1;
            end
            m_vs = vsync_i;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("en_o", 32'(en_o), 32'(m_ctrl[0]));
            check("test_pat_o", 32'(test_pat_o), 32'(m_ctrl[1]));
            check("bg_color_o", 32'(bg_color_o), m_bg);
            check("irq_o", 32'(irq_o), 32'(m_fd));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int cyc;
        bit aw_done, w_done;
        logic [1:0] exp_resp;
        exp_resp = m_bresp(addr);
        awaddr = addr; wdata = data; wstrb = strb;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            check("awready_idle", 32'(awready), 32'(!aw_done));
            check("wready_idle", 32'(wready), 32'(!w_done));
            check("bvalid_early", 32'(bvalid), 32'h0);
            if ((aw_done || awvalid) && (w_done || wvalid)) begin
                m_wa = addr; m_wd = data; m_ws = strb; m_commit = 1'b1;
            end
            aw_done = aw_done || awvalid;
            w_done  = w_done || wvalid;
            tick;
            m_commit = 1'b0;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        for (int i = 0; i <= b_dly; i++) begin
            if (i == b_dly) bready = 1'b1;
            @(negedge clk);
            check("bvalid", 32'(bvalid), 32'h1);
            check("bresp", 32'(bresp), 32'(exp_resp));
            check("awready_resp", 32'(awready), 32'h0);
            check("wready_resp", 32'(wready), 32'h0);
            tick;
        end
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] got, output logic [1:0] got_resp);
        logic [31:0] exp;
        logic [1:0]  er;
        araddr = addr;
        repeat (ar_dly) begin
            @(negedge clk);
            check("arready_idle", 32'(arready), 32'h1);
            tick;
        end
        arvalid = 1'b1;
        @(negedge clk);
        check("arready_hs", 32'(arready), 32'h1);
        exp = m_rdata(addr);
        er  = m_rresp(addr);
        tick;
        arvalid = 1'b0;
        got = 'x; got_resp = 'x;
        for (int i = 0; i <= r_dly; i++) begin
            if (i == r_dly) rready = 1'b1;
            @(negedge clk);
            if (i == 0) begin
                got = rdata;
                got_resp = rresp;
            end
            check("rvalid", 32'(rvalid), 32'h1);
            check("rdata", rdata, exp);
            check("rresp", 32'(rresp), 32'(er));
            check("arready_busy", 32'(arready), 32'h0);
            tick;
        end
        rready = 1'b0;
        @(negedge clk);
        check("rvalid_done", 32'(rvalid), 32'h0);
        tick;
    endtask

    logic [31:0] a_tab [8];
    logic [31:0] got, wa, ra;
    logic [1:0]  gresp;

    initial begin
        a_tab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h40};
        rst = 1'b1;
        araddr = 0; arvalid = 0; rready = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        vsync_i = 0; m_commit = 0; m_wa = 0; m_wd = 0; m_ws = 0;
        repeat (3) tick;
        started = 1'b1;
        @(negedge clk);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_wready", 32'(wready), 32'h0);
        check("rst_bvalid", 32'(bvalid), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        tick;
        rst = 1'b0;

        axi_read(32'h00, 0, 0, got, gresp);
        check("lit_ctrl_reset", got, 32'h0);
        axi_write(32'h00, 32'h3, 4'hF, 0, 3, 0);
        check("lit_en", 32'(en_o), 32'h1);
        check("lit_test_pat", 32'(test_pat_o), 32'h1);

        axi_write(32'h04, 32'hABC, 4'b0001, 1, 0, 1);
        check("lit_bg", 32'(bg_color_o), 32'h0BC);
        axi_read(32'h04, 0, 0, got, gresp);
        check("lit_bg_read", got, 32'h0000_00BC);

        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2);
        axi_read(32'h10, 1, 5, got, gresp);
        check("lit_scratch", got, 32'hDEADBEEF);

        repeat (3) begin
            vsync_i = 1'b1; tick;
            vsync_i = 1'b0; tick;
        end
        axi_read(32'h08, 0, 0, got, gresp);
        check("lit_status", got, 32'h0003_0000);
        check("lit_irq_set", 32'(irq_o), 32'h1);
        axi_write(32'h0C, 32'h1, 4'h1, 0, 0, 0);
        check("lit_irq_clr", 32'(irq_o), 32'h0);
        vsync_i = 1'b1;
        axi_write(32'h0C, 32'h1, 4'h1, 0, 0, 0);
        check("lit_irq_set_wins", 32'(irq_o), 32'h1);
        vsync_i = 1'b0;
        tick;

        axi_read(32'h40, 0, 0, got, gresp);
        check("lit_unmapped_data", got, 32'h0);
        check("lit_unmapped_resp", 32'(gresp), 32'h2);
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_read(32'h08, 0, 0, got, gresp);
        check("lit_status_ro", got, 32'h0004_0000);

        for (int it = 0; it < 200; it++) begin
            wa = a_tab[$urandom_range(7, 0)] | 32'($urandom_range(3, 0));
            ra = a_tab[$urandom_range(7, 0)] | 32'($urandom_range(3, 0));
            vsync_i = 1'($urandom_range(1, 0));
            fork
                axi_write(wa, $urandom, 4'($urandom), $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0));
                axi_read(ra, $urandom_range(2, 0), $urandom_range(2, 0), got, gresp);
            join
        end
        vsync_i = 1'b0;
        tick;

        awaddr = 32'h10; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        m_wa = 32'h10; m_wd = 32'h1234_5678; m_ws = 4'hF; m_commit = 1'b1;
        tick;
        m_commit = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", 32'(bvalid), 32'h1);
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        check("mid_rst_bvalid", 32'(bvalid), 32'h0);
        check("mid_rst_awready", 32'(awready), 32'h0);
        tick;
        rst = 1'b0;
        axi_read(32'h10, 0, 0, got, gresp);
        check("lit_scratch_rst", got, 32'h0);
        axi_read(32'h00, 0, 0, got, gresp);
        check("lit_ctrl_rst", got, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_axil_regs.md
Name: vga_axil_regs

Overview:
- AXI4-Lite slave terminating the vga_axil_if bus; holds the VGA control/status register bank.
- Sits directly downstream of the bus: the testbench/CPU master drives it, and it drives static control outputs into the VGA timing/pixel core.
- Independent read and write FSMs, byte-strobe writes, SLVERR for unmapped addresses.
- Sticky frame-done flag fed back from the core.

Parameters:
ADDR_W, 32, AXI-Lite address width (matches vga_axil_pkg::axil_addr_t)
DATA_W, 32, AXI-Lite data width; fixed at 32 for this register map
FRAME_CNT_W, 16, width of the internal frame counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
araddr  input  ADDR_W  read address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  DATA_W  read data
rresp  output  2  read response
rvalid  output  1  read data valid
rready  input  1  read data ready
awaddr  input  ADDR_W  write address
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  DATA_W  write data
wstrb  input  DATA_W/8  write byte strobes
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response
bvalid  output  1  write response valid
bready  input  1  write response ready
vsync_i  input  1  vsync from VGA core, same clk domain, active-high
en_o  output  1  CTRL.en
test_pat_o  output  1  CTRL.test_pattern
bg_color_o  output  12  BG_COLOR RGB444
irq_o  output  1  level copy of IRQ.frame_done

Behaviour:
- Register map (decode on addr[4:2]; addr[1:0] ignored; bits above 4 must be zero, else unmapped):
  - 0x00 CTRL RW: [0] en, [1] test_pattern.
  - 0x04 BG_COLOR RW: [11:0].
  - 0x08 STATUS RO: [0] current vsync_i, [FRAME_CNT_W+15:16] frame_cnt.
  - 0x0C IRQ W1C: [0] frame_done.
  - 0x10 SCRATCH RW: [31:0].
  - Unimplemented bits read 0. All registers reset to 0.
- Responses: OKAY=2'b00, SLVERR=2'b10.
  - Unmapped read: rdata=0, SLVERR.
  - Unmapped write or write to STATUS: no state change, SLVERR.
- Reset (rst=1): arready, awready, wready, rvalid and bvalid are all 0; rdata=0; rresp=bresp=OKAY; FSMs idle; all register outputs 0. Reset mid-transaction abandons it with no response.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE: awready = !aw_held; wready = !w_held. AW and W handshakes are independent and may occur in either order or in the same cycle. Address, data and strobes are latched.
  - On the edge where the second of the two handshakes completes: commit the write per wstrb (byte lanes), set bresp, go to W_RESP.
  - In W_RESP: bvalid=1 (one cycle after the commit edge); awready=wready=0. On bvalid&&bready, clear the held flags and return to W_IDLE.
  - Register outputs (en_o, etc.) update on the commit edge, so they are visible the next cycle.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE: arready=1. On arvalid handshake, decode and register rdata/rresp, go to R_DATA.
  - In R_DATA: rvalid=1 (latency 1 cycle); arready=0; rdata held stable until rready. Return to R_IDLE on rvalid&&rready.
  - Back-to-back reads sustain one read every 2 cycles.
- Read/write collision on the same register in the same edge: the read returns the pre-write value.
- vsync edge detect: vs_d <= vsync_i. rise = vsync_i & !vs_d. On rise: frame_cnt += 1 (wraps modulo 2^FRAME_CNT_W) and frame_done is set.
- IRQ W1C: writing 1 to bit 0 with wstrb[0]=1 clears frame_done. If a set and a clear occur in the same cycle, the set wins.
- irq_o = frame_done (registered).
- Outputs never depend combinationally on AXI inputs: readies are functions of FSM state only, gated low during rst.

Decomposition:
- vga_axil_pkg holds:
  - axil_addr_t, axil_data_t, axil_resp_t.
  - RESP_OKAY and RESP_SLVERR.
  - Register offset localparams: CTRL_OFS, BG_COLOR_OFS, STATUS_OFS, IRQ_OFS, SCRATCH_OFS.
  - A CTRL bit-field packed struct.
- One sub-module, vga_axil_strb_merge: combinational per-byte merge of old value, wdata and wstrb. Used for every RW register.

Test Plan:
- Reset then read 0x00 -> rdata=0, rresp=OKAY, rvalid exactly 1 cycle after the AR handshake.
- AW at cycle 0 and W at cycle 3 (wdata=0x3, wstrb=0xF) to 0x00 -> bvalid at cycle 4 with OKAY; en_o=1 and test_pat_o=1 from cycle 4.
- Write 0x04 with wdata=0xABC, wstrb=4'b0001, over an existing value of 0x000 -> bg_color_o=0x0BC; readback 0x000000BC.
- Write 0xDEADBEEF to 0x10, then read with rready held low 5 cycles -> rdata stable at 0xDEADBEEF and rvalid high throughout; arready stays 0 until the handshake.
- Pulse vsync_i 3 times, then read 0x08 -> frame_cnt=3 and irq_o=1. Write 0x1 to 0x0C -> irq_o=0. A W1C coinciding with a vsync rise leaves irq_o=1.
- Read 0x40 and write 0x08 -> rresp=SLVERR with rdata=0; bresp=SLVERR with STATUS unchanged. Assert rst while bvalid=1 -> bvalid=0 next cycle and all registers 0.
